// File: rtl/sine_phase_search.sv
// Inverts the quarter-wave sine table by binary search over the external ROM.
// Returns the principal phase: quadrant 0 for non-negative samples, quadrant 3 for negative ones.
module sine_phase_search #(
  parameter  int ROM_WIDTH = 8,
  parameter  int ROM_DEPTH = 64,
  localparam int A         = $clog2(ROM_DEPTH),
  localparam int P         = $clog2(4 * ROM_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2*ROM_WIDTH-1:0] sample,
  output logic                   busy,
  output logic [A-1:0]           rom_addr,
  input  logic [ROM_WIDTH-1:0]   rom_data,
  output logic                   done,
  output logic [P-1:0]           phase_id,
  output logic                   sat
);

  localparam int W  = ROM_WIDTH;
  localparam int SW = 2 * ROM_WIDTH;
  localparam logic [A-1:0] ONE     = {{(A-1){1'b0}}, 1'b1};
  localparam logic [SW:0]  MAG_MAX = {{(SW+1-W){1'b0}}, {W{1'b1}}};

  typedef enum logic [1:0] {IDLE, ADDR, CMP, DONE} state_t;

  state_t         state, state_next;
  logic [A-1:0]   k, b;
  logic [W-1:0]   mag;
  logic           sign, sat_next;

  logic           accept;
  logic [SW:0]    sample_ext, abs_val;
  logic           clip;
  logic [W-1:0]   mag_in;
  logic [A-1:0]   bit_mask, k_upd;
  logic [P-1:0]   phase_calc;

  // Extra magnitude bit lets the most negative sample invert without overflow.
  assign sample_ext = {sample[SW-1], sample};
  assign abs_val    = sample[SW-1] ? (~sample_ext + 1'b1) : sample_ext;
  assign clip       = abs_val > MAG_MAX;
  assign mag_in     = clip ? {W{1'b1}} : abs_val[W-1:0];

  assign accept     = start && (state == IDLE || state == DONE);
  assign bit_mask   = ONE << b;
  assign k_upd      = (rom_data <= mag) ? (k | bit_mask) : k;
  assign phase_calc = sign ? ({P{1'b1}} - {2'b00, k}) : {2'b00, k};
  assign busy       = (state == ADDR) || (state == CMP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ADDR;
      ADDR:    state_next = CMP;
      CMP:     state_next = (b == '0) ? DONE : ADDR;
      DONE:    state_next = start ? ADDR : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The probe address is registered on entry to ADDR so the ROM word is ready in CMP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k        <= '0;
      b        <= '0;
      mag      <= '0;
      sign     <= 1'b0;
      sat_next <= 1'b0;
      rom_addr <= '0;
      done     <= 1'b0;
      phase_id <= '0;
      sat      <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (state == DONE) begin
        phase_id <= phase_calc;
        sat      <= sat_next;
      end
      if (accept) begin
        sign     <= sample[SW-1];
        mag      <= mag_in;
        sat_next <= clip;
        k        <= '0;
        b        <= A'(A - 1);
        rom_addr <= ONE << (A - 1);
      end else if (state == CMP) begin
        k <= k_upd;
        if (b != '0) begin
          b        <= b - 1'b1;
          rom_addr <= k_upd | (bit_mask >> 1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sine_phase_search.sv
// Directed bench for sine_phase_search against a registered ROM holding q[k] = 4k+2.
module tb_sine_phase_search;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] sample = '0;
  logic        busy;
  logic [5:0]  rom_addr;
  logic [7:0]  rom_data = '0;
  logic        done;
  logic [7:0]  phase_id;
  logic        sat;

  int n_checks = 0;
  int n_errors = 0;

  sine_phase_search #(.ROM_WIDTH(8), .ROM_DEPTH(64)) dut (
    .clk(clk), .rst(rst), .start(start), .sample(sample), .busy(busy),
    .rom_addr(rom_addr), .rom_data(rom_data), .done(done),
    .phase_id(phase_id), .sat(sat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= {rom_addr, 2'b10};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Accepts one search, then measures done latency and busy duration.
  task automatic run_search(input string tag, input logic [15:0] s,
                            input int exp_phase, input int exp_sat);
    int edges;
    int busy_cyc;
    sample = s;
    start  = 1'b1;
    edge1();
    start    = 1'b0;
    edges    = 0;
    busy_cyc = busy ? 1 : 0;
    while (!done && edges < 40) begin
      edge1();
      edges++;
      if (busy) busy_cyc++;
    end
    chk({tag, "_latency"}, edges, 13);
    chk({tag, "_busy_cycles"}, busy_cyc, 12);
    chk({tag, "_phase"}, phase_id, exp_phase);
    chk({tag, "_sat"}, sat, exp_sat);
    edge1();
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int edges;
    int done_cnt;

    #3 rst = 1'b0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_phase", phase_id, 0);
    chk("rst_sat", sat, 0);
    chk("rst_addr", rom_addr, 0);
    edge1();
    edge1();
    rst = 1'b1;
    edge1();

    // First probe address and the final address held after completion.
    sample = 16'd102;
    start  = 1'b1;
    edge1();
    start = 1'b0;
    chk("first_addr", rom_addr, 32);
    chk("busy_after_accept", busy, 1);
    repeat (14) edge1();
    chk("addr_held", rom_addr, 25);
    chk("p102_phase", phase_id, 25);

    run_search("pos102", 16'd102, 25, 0);
    run_search("neg102", -16'sd102, 230, 0);
    run_search("zero", 16'd0, 0, 0);
    run_search("pos300", 16'd300, 63, 1);
    run_search("neg32768", 16'h8000, 192, 1);
    run_search("pos6", 16'd6, 1, 0);
    run_search("pos1", 16'd1, 0, 0);
    run_search("neg255", -16'sd255, 192, 0);

    // A start pulse during a search must be ignored.
    sample = 16'd102;
    start  = 1'b1;
    edge1();
    start = 1'b0;
    repeat (3) edge1();
    sample = 16'd6;
    start  = 1'b1;
    edge1();
    start    = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        done_cnt++;
        chk("ignored_phase", phase_id, 25);
      end
      edge1();
    end
    chk("ignored_done_count", done_cnt, 1);

    // Start held through DONE is accepted back to back.
    sample = 16'd102;
    start  = 1'b1;
    edge1();
    sample = 16'd6;
    edges  = 0;
    while (!done && edges < 40) begin
      edge1();
      edges++;
    end
    start = 1'b0;
    chk("b2b_first_latency", edges, 13);
    chk("b2b_first_phase", phase_id, 25);
    chk("b2b_busy_again", busy, 1);
    edges = 0;
    do begin
      edge1();
      edges++;
    end while (!done && edges < 40);
    chk("b2b_second_latency", edges, 13);
    chk("b2b_second_phase", phase_id, 1);
    edge1();

    // Asynchronous reset in the middle of a search.
    sample = -16'sd102;
    start  = 1'b1;
    edge1();
    start = 1'b0;
    repeat (5) edge1();
    chk("pre_reset_busy", busy, 1);
    chk("pre_reset_phase", phase_id, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_phase", phase_id, 0);
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) done_cnt++;
      edge1();
    end
    chk("mid_rst_no_done", done_cnt, 0);
    rst = 1'b1;
    edge1();
    run_search("after_rst", 16'd102, 25, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sine_phase_search.md
Name: sine_phase_search

Overview:
- Inverse of the quarter-wave sine lookup: takes a signed sine sample and returns the phase index whose table value matches it.
- Reads the same quarter-wave ROM through an external single-port read interface with registered output, one-cycle latency.
- Performs a successive-approximation (binary) search over the monotonic quarter table.
- Output is the principal phase (asin range): quadrant 0 for non-negative samples, quadrant 3 for negative samples, in the same id encoding the sine table consumes.

Parameters:
ROM_WIDTH, 8, bit width of each quarter-table entry (unsigned magnitude).
ROM_DEPTH, 64, quarter-table entries; power of two, >= 2. Internal A = $clog2(ROM_DEPTH), P = $clog2(4*ROM_DEPTH).

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  asynchronous, active-low reset.
start  in  1  request pulse; sampled only when idle (IDLE or DONE state).
sample  in  2*ROM_WIDTH  signed sine value to invert; captured on the accepting edge.
busy  out  1  high while a search is in progress.
rom_addr  out  A  registered quarter-table read address.
rom_data  in  ROM_WIDTH  table entry q[rom_addr], valid one cycle after the address is presented.
done  out  1  one-cycle pulse when the result is valid.
phase_id  out  P  resulting phase index; held until the next accepted start.
sat  out  1  sample magnitude exceeded the table range; held with phase_id.

Behaviour:
- Reset (rst=0, async): state=IDLE; busy, done, sat, rom_addr, phase_id all 0; internal k, bit pointer, mag and sign all 0.
- Capture on accept:
  - sign = sample[MSB].
  - mag = |sample|, computed in 2*ROM_WIDTH+1 bits so -2^(2W-1) is handled.
  - If mag > 2^ROM_WIDTH-1: mag clipped to 2^ROM_WIDTH-1 and sat_next=1.
  - k=0, b=A-1; state -> ADDR; busy=1.
- FSM states: IDLE, ADDR, CMP, DONE.
  - IDLE: wait for start.
  - ADDR: rom_addr = k | (1<<b); -> CMP.
  - CMP: if rom_data <= mag then k = k | (1<<b). If b==0 -> DONE, else b-1 and -> ADDR.
  - DONE: done=1, busy=0, phase_id/sat updated this cycle; -> IDLE, or -> ADDR if start is high (back-to-back accept).
- Result:
  - k = largest index with q[k] <= mag; 0 if mag < q[0].
  - phase_id = k when sign=0; phase_id = 4*ROM_DEPTH-1-k when sign=1 (quadrant 3 mirror).
- Latency: done rises exactly 2*A+1 edges after the edge that sampled start (13 for defaults). busy is high for 2*A cycles.
- start while busy: ignored; sample is not re-captured.
- Zero sample: treated as non-negative.
- Equal table entries: the highest matching index wins.
- rom_addr holds its last value outside ADDR.
- Reset mid-search: immediate return to IDLE. No done pulse. phase_id is cleared to 0.
- Width rules: comparisons are unsigned at ROM_WIDTH bits after clipping. No other truncation.

Test Plan:
- Bench ROM model q[k]=4k+2, 1-cycle registered, defaults. sample=+102 -> done after 13 edges; phase_id=25, sat=0.
- sample=-102 -> phase_id=230 (255-25), sat=0. sample=0 -> phase_id=0, sat=0.
- sample=+300 -> sat=1, phase_id=63. sample=-32768 -> sat=1, phase_id=192.
- Pulse start again 3 cycles after the first accept with sample=+6 -> ignored. First result (25) is reported and no second done pulse occurs.
- Start held high through DONE with sample=+6 -> second search accepted in the DONE cycle; phase_id=1 exactly 13 edges later.
- Assert rst low at cycle 5 of a search -> busy=0, done=0, phase_id=0 immediately (asynchronously). A new start after release gives a correct result.
